// File: rtl/count_seq_checker.sv
// Receive-side monitor for the 3-bit mode-controlled counter: predicts each
// sample from the previous one, acquires lock, and tallies deviations seen while locked.
module count_seq_checker #(
    parameter int LOCK_COUNT = 2,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clock,
    input  logic                 nreset,
    input  logic                 enable,
    input  logic                 mode_in,
    input  logic [2:0]           count_in,
    input  logic                 clear_err,
    output logic                 locked,
    output logic                 mismatch,
    output logic [2:0]           expected,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 err_sat,
    output logic [1:0]           state
);

    // Handshake: there is no ready; a sample is consumed on every rising edge
    // where enable=1, and every output is a register updated on that edge.

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACQUIRE = 2'b01,
        LOCKED  = 2'b10,
        LOST    = 2'b11
    } state_t;

    localparam logic [3:0]           LOCK_THR  = 4'(LOCK_COUNT);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX   = '1;
    localparam logic [ERR_CNT_W-1:0] ERR_ONE   = ERR_CNT_W'(1);
    localparam logic                 SAT_AT_ONE = (ERR_CNT_W == 1);

    state_t     cur_state, nxt_state;
    logic [2:0] prev_count;
    logic       prev_mode;
    logic [3:0] match_cnt, nxt_match_cnt;
    logic       hit;
    logic       lock_miss;

    function automatic logic [2:0] predict(input logic [2:0] c, input logic m);
        logic [2:0] r;
        if (!m) begin
            r = c + 3'd1;
        end else begin
            case (c)
                3'd2:    r = 3'd6;
                3'd6:    r = 3'd7;
                3'd7:    r = 3'd5;
                default: r = c;
            endcase
        end
        return r;
    endfunction

    assign hit    = (count_in == predict(prev_count, prev_mode));
    assign state  = cur_state;
    assign locked = (cur_state == LOCKED);

    always_comb begin
        nxt_state     = cur_state;
        nxt_match_cnt = match_cnt;
        lock_miss     = 1'b0;
        if (enable) begin
            case (cur_state)
                IDLE: begin
                    nxt_state     = ACQUIRE;
                    nxt_match_cnt = 4'd0;
                end
                ACQUIRE: begin
                    if (hit) begin
                        nxt_match_cnt = match_cnt + 4'd1;
                        if (match_cnt + 4'd1 >= LOCK_THR) nxt_state = LOCKED;
                    end else begin
                        nxt_match_cnt = 4'd0;
                    end
                end
                LOCKED: begin
                    if (!hit) begin
                        nxt_state = LOST;
                        lock_miss = 1'b1;
                    end
                end
                LOST: begin
                    if (hit) begin
                        nxt_match_cnt = 4'd1;
                        nxt_state     = (LOCK_THR == 4'd1) ? LOCKED : ACQUIRE;
                    end
                end
                default: nxt_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            cur_state  <= IDLE;
            match_cnt  <= 4'd0;
            prev_count <= 3'd0;
            prev_mode  <= 1'b0;
            expected   <= 3'd0;
            mismatch   <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            match_cnt <= nxt_match_cnt;
            mismatch  <= lock_miss;
            if (enable) begin
                prev_count <= count_in;
                prev_mode  <= mode_in;
                expected   <= predict(count_in, mode_in);
            end
        end
    end

    // A miss on the clearing edge still counts: the tally restarts at one.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            err_count <= '0;
            err_sat   <= 1'b0;
        end else if (clear_err) begin
            err_count <= lock_miss ? ERR_ONE : '0;
            err_sat   <= lock_miss && SAT_AT_ONE;
        end else if (lock_miss && (err_count != ERR_MAX)) begin
            err_count <= err_count + ERR_ONE;
            if (err_count == ERR_MAX - ERR_ONE) err_sat <= 1'b1;
        end
    end

endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
- Receive-side monitor for the 3-bit mode-controlled complex counter.
- Samples the counter's count and mode lines and predicts each next value from the counter's transition table.
- Locks onto the stream, flags deviations and keeps a saturating error tally.
- Sits beside the counter in the test/diagnostic path; drives status only and has no effect on the counter.

Parameters:
- LOCK_COUNT, 2: consecutive correct predictions required to declare lock; legal range 1..15.
- ERR_CNT_W, 8: width of the error counter.

Ports:
- clock  input  1  rising-edge sample clock. Same net as the counter's clock; the counter updates on the falling edge, so inputs are mid-cycle stable here.
- nreset  input  1  reset, asynchronous, active-low.
- enable  input  1  sample qualifier; the checker acts only on rising edges with enable=1.
- mode_in  input  1  counter mode line. Must be stable from this rising edge through the following falling edge.
- count_in  input  3  counter output value.
- clear_err  input  1  synchronous clear of err_count and err_sat.
- locked  output  1  high while in LOCKED.
- mismatch  output  1  one-cycle pulse on a detected error while LOCKED.
- expected  output  3  predicted value for the next enabled sample.
- err_count  output  ERR_CNT_W  saturating count of errors detected while LOCKED.
- err_sat  output  1  sticky; high once err_count reaches all-ones.
- state  output  2  IDLE=00, ACQUIRE=01, LOCKED=10, LOST=11.

Behaviour:
- Reset (nreset low, any time, including mid-operation): state=IDLE, locked=0, mismatch=0, expected=0, err_count=0, err_sat=0. Internal prev_count=0, prev_mode=0, match_cnt=0.
- Prediction function f(c,m):
  - m=0: binary increment with wrap; 7→0.
  - m=1: 0→0, 1→1, 2→6, 3→3, 4→4, 5→5, 6→7, 7→5.
- On every enabled sample: prev_count←count_in, prev_mode←mode_in, expected←f(count_in, mode_in). The comparison always uses the values held before the update.
- hit = (count_in == f(prev_count, prev_mode)).
- IDLE: first enabled sample seeds prev and goes to ACQUIRE with match_cnt=0. No comparison on this sample.
- ACQUIRE:
  - hit: match_cnt++. Enter LOCKED when match_cnt reaches LOCK_COUNT (checked on the incremented value).
  - miss: match_cnt←0, stay in ACQUIRE, no error counted.
- LOCKED:
  - hit: stay.
  - miss: mismatch=1 for exactly the next clock cycle, err_count+1 (saturating), go to LOST, locked=0 on the same edge.
- LOST:
  - miss: stay; no further errors counted.
  - hit: go to ACQUIRE with match_cnt=1. If LOCK_COUNT==1, go directly to LOCKED.
- enable=0: all state, prev registers, expected, match_cnt and err_count hold. mismatch is 0 on any cycle whose preceding edge was not an enabled miss in LOCKED.
- locked is registered: asserted on the same edge that enters LOCKED.
- err_count saturates at 2^ERR_CNT_W−1. err_sat is set on the edge it reaches that value and stays set until clear_err or reset.
- clear_err: err_count←0 and err_sat←0 on the next rising edge; applied regardless of enable.
  - If a LOCKED miss occurs on the same edge, err_count←1 and err_sat←0 (unless ERR_CNT_W==1, in which case err_sat←1).
  - The mismatch pulse is still generated.
- A mode change between samples is legal. The prediction uses the mode captured with the previous sample.
- No X propagation on outputs after reset. Outputs are undefined only while nreset is low-to-high within the recovery window.

Test Plan:
- Reset mid-LOCKED with err_count=3 → on nreset low, all outputs 0 immediately (async); state=00.
- mode_in=0, count_in 0,1,2,3…7,0 with enable=1 → state 00→01 after sample 1, LOCKED after sample 3 (two hits). Stays locked across the 7→0 wrap. mismatch never pulses.
- mode_in=1, count_in 2,6,7,5,5,5 → locks after 7; expected=5 after samples 7 and 5; err_count stays 0.
- Locked on mode 0, inject 3,4,6,7,0 → single mismatch pulse the cycle after sample 6, err_count=1, state=LOST. After sample 7 (hit): ACQUIRE. After 0: LOCKED.
- ERR_CNT_W=2: four lock/error/relock cycles → err_count=3, err_sat=1, remains 3 on a fifth error. Assert clear_err coincident with a sixth error → err_count=1, err_sat=0.
- Locked sequence with enable toggling 1,0,0,1 (count_in holding garbage while enable=0) → no state change, no mismatch, lock retained on the next valid value.
